// File: rtl/output_acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : output_acc_buffer
//  Description : Partial-sum buffer sitting directly behind the MAC. Keeps one
//                accumulator entry per output position and presents the entry
//                at the write pointer as the MAC accumulate operand. Each
//                returned sum is written back. Input-channel passes are
//                counted. When all passes are done, the finished entries
//                drain over a valid/ready stream. Each entry is cleared as it
//                drains, so the next tile starts from zero.
//  Ports       : clk_i, rst_i (async, active low)
//                start_i, num_out_i, num_pass_i   - tile control (IDLE only)
//                acc_dat_o / acc_val_i, acc_dat_i - MAC accumulate loop
//                out_valid_o, out_ready_i, out_data_o, out_last_o - drain
//                busy_o, ovf_err_o                - status
//  Options     : OUT_RELU_EN - when defined, negative drained values are
//                              clamped to zero on out_data_o only.
//  Revision    : 1.0 - initial release
// ============================================================================
`ifndef OUTPUT_BUF_SIZE
`define OUTPUT_BUF_SIZE 32
`endif

module output_acc_buffer #(
    parameter int DATA_W = `OUTPUT_BUF_SIZE,
    parameter int DEPTH  = 16,
    parameter int PASS_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic [$clog2(DEPTH):0]   num_out_i,
    input  logic [PASS_W-1:0]        num_pass_i,
    output logic [DATA_W-1:0]        acc_dat_o,
    input  logic                     acc_val_i,
    input  logic [DATA_W-1:0]        acc_dat_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [DATA_W-1:0]        out_data_o,
    output logic                     out_last_o,
    output logic                     busy_o,
    output logic                     ovf_err_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_ACCUM = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PASS_W-1:0] r_pass_cnt;
    logic [CNT_W-1:0]  r_num_out;
    logic [PASS_W-1:0] r_num_pass;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_ovf_err;

    logic              w_acc_we;
    logic              w_wr_last;
    logic              w_pass_last;
    logic              w_rd_last;
    logic              w_out_fire;
    logic [CNT_W-1:0]  w_num_out_eff;
    logic [PASS_W-1:0] w_num_pass_eff;
    logic [DATA_W-1:0] w_rd_data;

    // A zero count would never terminate a tile, so it is promoted to one.
    assign w_num_out_eff  = (num_out_i  == '0) ? CNT_W'(1)  : num_out_i;
    assign w_num_pass_eff = (num_pass_i == '0) ? PASS_W'(1) : num_pass_i;

    assign w_acc_we    = (r_state == c_ST_ACCUM) && acc_val_i;
    assign w_wr_last   = ({1'b0, r_wr_ptr} == (r_num_out - CNT_W'(1)));
    assign w_pass_last = (r_pass_cnt == (r_num_pass - PASS_W'(1)));
    assign w_rd_last   = ({1'b0, r_rd_ptr} == (r_num_out - CNT_W'(1)));
    assign w_out_fire  = (r_state == c_ST_DRAIN) && out_ready_i;

    // ------------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start_i) w_state_next = c_ST_ACCUM;
            end
            c_ST_ACCUM: begin
                // Final write of the final pass: results are complete.
                if (w_acc_we && w_wr_last && w_pass_last) w_state_next = c_ST_DRAIN;
            end
            c_ST_DRAIN: begin
                if (w_out_fire && w_rd_last) w_state_next = c_ST_IDLE;
            end
            default: w_state_next = c_ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Pointers, counters and tile configuration
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_pass_cnt <= '0;
            r_num_out  <= '0;
            r_num_pass <= '0;
            r_ovf_err  <= 1'b0;
        end else begin
            if ((r_state == c_ST_IDLE) && start_i) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_pass_cnt <= '0;
                r_num_out  <= w_num_out_eff;
                r_num_pass <= w_num_pass_eff;
            end
            if (w_acc_we) begin
                if (w_wr_last) begin
                    r_wr_ptr   <= '0;
                    r_pass_cnt <= r_pass_cnt + PASS_W'(1);
                end else begin
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
            end
            if (w_out_fire) begin
                r_rd_ptr <= w_rd_last ? '0 : r_rd_ptr + PTR_W'(1);
            end
            // MAC results outside ACCUM have no slot to land in.
            if (acc_val_i && (r_state != c_ST_ACCUM)) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Accumulator storage: written by the MAC, cleared as entries drain.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_acc_we) begin
                r_mem[r_wr_ptr] <= acc_dat_i;
            end else if (w_out_fire) begin
                r_mem[r_rd_ptr] <= '0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign acc_dat_o = r_mem[r_wr_ptr];
    assign w_rd_data = r_mem[r_rd_ptr];

`ifdef OUT_RELU_EN
    assign out_data_o = w_rd_data[DATA_W-1] ? '0 : w_rd_data;
`else
    assign out_data_o = w_rd_data;
`endif

    assign out_valid_o = (r_state == c_ST_DRAIN);
    assign out_last_o  = (r_state == c_ST_DRAIN) && w_rd_last;
    assign busy_o      = (r_state != c_ST_IDLE);
    assign ovf_err_o   = r_ovf_err;

endmodule

`default_nettype wire

// File: tb/tb_output_acc_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_output_acc_buffer
//  Description : Directed, table-driven testbench for output_acc_buffer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_output_acc_buffer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 16;
    localparam int PASS_W = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk_i = 1'b0;
    logic              rst_i = 1'b0;
    logic              start_i = 1'b0;
    logic [CNT_W-1:0]  num_out_i = '0;
    logic [PASS_W-1:0] num_pass_i = '0;
    logic [DATA_W-1:0] acc_dat_o;
    logic              acc_val_i = 1'b0;
    logic [DATA_W-1:0] acc_dat_i = '0;
    logic              out_valid_o;
    logic              out_ready_i = 1'b0;
    logic [DATA_W-1:0] out_data_o;
    logic              out_last_o;
    logic              busy_o;
    logic              ovf_err_o;

    output_acc_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PASS_W (PASS_W)
    ) u_dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .num_out_i   (num_out_i),
        .num_pass_i  (num_pass_i),
        .acc_dat_o   (acc_dat_o),
        .acc_val_i   (acc_val_i),
        .acc_dat_i   (acc_dat_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_data_o  (out_data_o),
        .out_last_o  (out_last_o),
        .busy_o      (busy_o),
        .ovf_err_o   (ovf_err_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int num_out;   // value driven on num_out_i
        int num_pass;  // value driven on num_pass_i
        int inc;       // amount the modelled MAC adds per result
        int eff_out;   // entries actually used
        int eff_pass;  // passes actually run
        int exp_sum;   // hand-computed final value of every entry
    } vec_t;

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    function automatic longint relu(input longint v);
`ifdef OUT_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic do_start(input int n_out, input int n_pass);
        start_i    = 1'b1;
        num_out_i  = CNT_W'(n_out);
        num_pass_i = PASS_W'(n_pass);
        tick();
        start_i = 1'b0;
        check("busy_after_start", busy_o, 1);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        #3;
        check("rst_acc_dat", acc_dat_o, 0);
        check("rst_valid", out_valid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_ovf", ovf_err_o, 0);
        tick();
        rst_i = 1'b1;
        tick();
    endtask

    // Runs every pass back-to-back; the MAC model adds inc to the operand.
    task automatic accumulate(input int eff_out, input int eff_pass, input int inc);
        for (int p = 0; p < eff_pass; p++) begin
            for (int e = 0; e < eff_out; e++) begin
                check("acc_operand", longint'($signed(acc_dat_o)), longint'(p) * inc);
                acc_val_i = 1'b1;
                acc_dat_i = acc_dat_o + DATA_W'(inc);
                tick();
            end
        end
        acc_val_i = 1'b0;
        check("drain_latency_valid", out_valid_o, 1);
    endtask

    task automatic drain_all(input int eff_out, input int exp_sum);
        for (int i = 0; i < eff_out; i++) begin
            out_ready_i = 1'b1;
            check("drain_valid", out_valid_o, 1);
            check("drain_data", longint'($signed(out_data_o)), relu(exp_sum));
            check("drain_last", out_last_o, (i == eff_out - 1) ? 1 : 0);
            tick();
        end
        out_ready_i = 1'b0;
        check("post_drain_valid", out_valid_o, 0);
        check("post_drain_busy", busy_o, 0);
    endtask

    vec_t vecs[6];
    int   bp_exp[3];
    int   idx;

    initial begin
        vecs[0] = '{num_out: 4,  num_pass: 1, inc: 10,  eff_out: 4,  eff_pass: 1, exp_sum: 10};
        vecs[1] = '{num_out: 3,  num_pass: 3, inc: 5,   eff_out: 3,  eff_pass: 3, exp_sum: 15};
        vecs[2] = '{num_out: 3,  num_pass: 1, inc: 7,   eff_out: 3,  eff_pass: 1, exp_sum: 7};
        vecs[3] = '{num_out: 0,  num_pass: 0, inc: 3,   eff_out: 1,  eff_pass: 1, exp_sum: 3};
        vecs[4] = '{num_out: 16, num_pass: 2, inc: -2,  eff_out: 16, eff_pass: 2, exp_sum: -4};
        vecs[5] = '{num_out: 2,  num_pass: 4, inc: 100, eff_out: 2,  eff_pass: 4, exp_sum: 400};

        // Reset state
        do_reset();
        check("idle_valid", out_valid_o, 0);
        check("idle_last", out_last_o, 0);
        check("idle_data", out_data_o, 0);

        // Table-driven tiles; each must start from cleared entries.
        for (int t = 0; t < 6; t++) begin
            do_start(vecs[t].num_out, vecs[t].num_pass);
            accumulate(vecs[t].eff_out, vecs[t].eff_pass, vecs[t].inc);
            drain_all(vecs[t].eff_out, vecs[t].exp_sum);
        end
        check("no_ovf_normal", ovf_err_o, 0);

        // Backpressure with distinct per-entry values 4, 8, 12.
        bp_exp[0] = 4; bp_exp[1] = 8; bp_exp[2] = 12;
        do_start(3, 1);
        for (int e = 0; e < 3; e++) begin
            acc_val_i = 1'b1;
            acc_dat_i = acc_dat_o + DATA_W'((e + 1) * 4);
            tick();
        end
        acc_val_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("bp_hold_valid", out_valid_o, 1);
            check("bp_hold_data", out_data_o, 4);
            check("bp_hold_last", out_last_o, 0);
            // Late MAC result during DRAIN must be dropped and flagged.
            acc_val_i = (k == 2) ? 1'b1 : 1'b0;
            acc_dat_i = 32'd999;
            tick();
        end
        acc_val_i = 1'b0;
        check("ovf_in_drain", ovf_err_o, 1);
        idx = 0;
        for (int k = 0; k < 20 && idx < 3; k++) begin
            out_ready_i = k[0];
            check("bp_valid", out_valid_o, 1);
            check("bp_data", out_data_o, bp_exp[idx]);
            check("bp_last", out_last_o, (idx == 2) ? 1 : 0);
            tick();
            if (k[0]) idx++;
        end
        out_ready_i = 1'b0;
        check("bp_all_drained", idx, 3);
        check("bp_idle", busy_o, 0);

        // acc_val_i in IDLE sets the sticky error; only reset clears it.
        do_reset();
        acc_val_i = 1'b1;
        acc_dat_i = 32'd55;
        tick();
        acc_val_i = 1'b0;
        check("ovf_in_idle", ovf_err_o, 1);
        check("idle_no_write", acc_dat_o, 0);
        tick();
        check("ovf_sticky", ovf_err_o, 1);
        do_reset();

        // start_i during ACCUM is ignored: tile keeps num_out=2.
        do_start(2, 1);
        acc_val_i = 1'b1;
        acc_dat_i = 32'd21;
        tick();
        acc_val_i  = 1'b0;
        start_i    = 1'b1;
        num_out_i  = CNT_W'(1);
        num_pass_i = PASS_W'(1);
        tick();
        start_i = 1'b0;
        check("restart_ignored_valid", out_valid_o, 0);
        acc_val_i = 1'b1;
        acc_dat_i = 32'd21;
        tick();
        acc_val_i = 1'b0;
        drain_all(2, 21);

        // Reset mid-ACCUM discards the partial entries.
        do_start(2, 1);
        acc_val_i = 1'b1;
        acc_dat_i = 32'd77;
        tick();
        acc_val_i = 1'b0;
        do_reset();
        do_start(2, 1);
        accumulate(2, 1, 6);
        drain_all(2, 6);

        // Signed results: negative entry is clamped on output only with RELU.
        do_start(2, 1);
        acc_val_i = 1'b1;
        acc_dat_i = -32'sd7;
        tick();
        acc_dat_i = 32'd9;
        tick();
        acc_val_i = 1'b0;
        out_ready_i = 1'b1;
        check("relu_data0", longint'($signed(out_data_o)), relu(-7));
        tick();
        check("relu_data1", longint'($signed(out_data_o)), 9);
        check("relu_last1", out_last_o, 1);
        tick();
        out_ready_i = 1'b0;
        check("relu_done", busy_o, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/output_acc_buffer.md
Name: output_acc_buffer

Overview:
- Partial-sum buffer directly downstream of the compute unit's MAC.
- Holds one accumulator entry per output position and presents the current entry as the MAC's accumulate input.
- Writes back each returned sum, counts input-channel passes, then drains finished results over a valid/ready stream to the writeback stage.
- Entries are cleared as they drain, so the next tile starts from zero.

Parameters:
- DATA_W, `OUTPUT_BUF_SIZE, width of one accumulator entry (two's complement).
- DEPTH, 16, number of accumulator entries (power of 2, >=2).
- PASS_W, 8, width of the pass counter.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  asynchronous active-low reset.
- start_i  in  1  one-cycle pulse, begins a tile; sampled only in IDLE.
- num_out_i  in  $clog2(DEPTH)+1  entries used per tile (1..DEPTH); sampled on start_i.
- num_pass_i  in  PASS_W  channel passes per tile (>=1); sampled on start_i.
- acc_dat_o  out  DATA_W  current entry mem[wr_ptr] to MAC accumulate input.
- acc_val_i  in  1  MAC result valid, one cycle per result.
- acc_dat_i  in  DATA_W  MAC result (old entry + products).
- out_valid_o  out  1  drain data valid.
- out_ready_i  in  1  downstream ready.
- out_data_o  out  DATA_W  drained result.
- out_last_o  out  1  marks last entry of tile.
- busy_o  out  1  state != IDLE.
- ovf_err_o  out  1  sticky: acc_val_i arrived outside ACCUM.

Behaviour:
- Reset (rst_i low, asynchronous):
  - state=IDLE; wr_ptr=rd_ptr=0; pass_cnt=0; all mem entries=0; latched num_out/num_pass=0.
  - Outputs: out_valid_o=0, out_last_o=0, busy_o=0, ovf_err_o=0.
  - acc_dat_o=mem[0]=0; out_data_o=0.
- States:
  - IDLE: start_i -> ACCUM; latches num_out_i/num_pass_i; clears wr_ptr, rd_ptr, pass_cnt.
  - ACCUM:
    - acc_dat_o is combinational from mem[wr_ptr] (zero latency to the MAC).
    - On acc_val_i: mem[wr_ptr]<=acc_dat_i (no saturation, wraps at DATA_W).
    - If wr_ptr==num_out-1: wr_ptr<=0 and pass_cnt<=pass_cnt+1; otherwise wr_ptr<=wr_ptr+1.
    - Writing the last entry when pass_cnt==num_pass-1 -> DRAIN on the next cycle.
  - DRAIN:
    - out_valid_o=1; out_data_o=mem[rd_ptr]; out_last_o=(rd_ptr==num_out-1).
    - On out_valid_o&&out_ready_i: mem[rd_ptr]<=0, rd_ptr<=rd_ptr+1.
    - Handshake on last -> IDLE, rd_ptr=0, out_valid_o deasserts the following cycle.
    - out_data_o/out_last_o must hold stable while valid&&!ready.
- acc_val_i in IDLE or DRAIN: dropped, no memory write, ovf_err_o<=1 (sticky until reset).
- start_i outside IDLE is ignored.
- num_out_i=0 on start is treated as 1; num_pass_i=0 is treated as 1.
- acc_dat_o after a wrap shows mem[0] in the cycle after the write.
- Back-to-back acc_val_i every cycle must be supported with no bubble.
- Reset mid-ACCUM or mid-DRAIN discards all entries.
- Latency from the final write-back to first out_valid_o: 1 cycle.

Optional Feature:
- Macro: OUT_RELU_EN.
- Defined: out_data_o = (mem[rd_ptr] signed negative) ? 0 : mem[rd_ptr]. The stored value is unaffected; acc_dat_o is never clamped.
- Undefined: out_data_o is the raw stored sum.

Test Plan:
- Reset check: assert reset -> acc_dat_o=0, out_valid_o=0, busy_o=0, ovf_err_o=0.
- Single pass: start with num_out=4, num_pass=1; MAC returns acc_dat_o+10 for each of 4 results -> drain 10,10,10,10 with out_last_o on the 4th; busy_o=0 afterwards.
- Multi-pass wrap: num_out=3, num_pass=3, each result +5 -> after 9 results, drain 15,15,15. Check acc_dat_o reads back 5 then 10 on later passes. Start a second tile -> entries begin at 0.
- Backpressure: during DRAIN hold out_ready_i=0 for 5 cycles, then toggle -> data and last stay stable, no entry lost or duplicated.
- Misuse: pulse acc_val_i during DRAIN and in IDLE -> ovf_err_o=1, drained values unchanged. start_i during ACCUM -> ignored.
- OUT_RELU_EN: num_out=2, results -7 and 9 -> with macro defined, drain 0,9; without it, drain -7,9.
